// File: rtl/pwm_bank_if.sv
// pwm_bank_if -- register write bus for pwm_bank.
//
// Signals:
//   wr_valid  write strobe, one register write per asserted cycle
//   wr_addr   8-bit register address
//   wr_data   8-bit register write data
//
// Modports:
//   master  drives the write bus (host / testbench side)
//   slave   receives the write bus (pwm_bank side)
interface pwm_bank_if;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_valid, wr_addr, wr_data);
    modport slave  (input  wr_valid, wr_addr, wr_data);
endinterface

// File: rtl/pwm_bank.sv
// pwm_bank -- bank of N_CH phase-aligned 8-bit PWM channels sharing a single
// prescaled counter.
//
// Parameters:
//   N_CH      number of channels (1..64)
//   PRESCALE  clk cycles per PWM counter tick (>=1); period = 255*PRESCALE clk
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   wr            pwm_bank_if.slave write bus (wr_valid / wr_addr / wr_data)
//   out[N_CH]     registered channel outputs
//   period_start  one-cycle pulse on the first cycle of every PWM period
//
// Register map (K = ceil(N_CH/8), write-only):
//   0x00+k out_en byte k, 0x10+k pwm_en byte k, 0x20+ch duty[ch],
//   0x30+k polarity byte k. Anything else is ignored.
//
// Build option:
//   PWM_BANK_SHADOW_EN  duty writes go to shadow registers that are copied
//                       into the active duty on the counter wrap 254->0, so
//                       a period never sees a mid-period duty change.
module pwm_bank #(
    parameter int N_CH     = 16,
    parameter int PRESCALE = 13
) (
    input  logic            clk,
    input  logic            rst,
    pwm_bank_if.slave       wr,
    output logic [N_CH-1:0] out,
    output logic            period_start
);

    localparam int            K          = (N_CH + 7) / 8;
    localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    CNT_LAST   = 8'd254;
    localparam logic [7:0]    POL_BASE   = 8'h30;
    localparam logic [7:0]    POL_END    = 8'(8'h30 + K);

    // Duty 0xFF must be constant high; counter < 0xFF already holds for
    // 0..254 but the explicit case keeps the intent obvious.
    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] duty);
        if (duty == 8'hFF) begin
            return 1'b1;
        end
        return (cnt < duty);
    endfunction

    logic [PW-1:0]   presc_p0;
    logic [7:0]      cnt_p0;
    logic            tick_p0;
    logic            wrap_p0;

    logic [N_CH-1:0] out_en;
    logic [N_CH-1:0] pwm_en;
    logic [N_CH-1:0] polarity;
    logic [7:0]      duty_act [N_CH];

    logic [N_CH-1:0] en_we;
    logic [N_CH-1:0] pe_we;
    logic [N_CH-1:0] pol_we;
    logic [N_CH-1:0] duty_we;
    logic [N_CH-1:0] wr_bit;
    logic            pol_addr_hit;

    logic [N_CH-1:0] raw_p0;
    logic [N_CH-1:0] out_nxt_p0;

    assign tick_p0 = (presc_p0 == PRESC_LAST);
    assign wrap_p0 = tick_p0 && (cnt_p0 == CNT_LAST);

    // For N_CH > 16 the duty range runs into the polarity bytes; polarity wins.
    assign pol_addr_hit = (wr.wr_addr >= POL_BASE) && (wr.wr_addr < POL_END);

    // Per-channel address decode and output logic. Bits of the last byte
    // above N_CH-1 have no channel here, so writes to them vanish.
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        localparam logic [7:0] BYTE_OFS  = 8'(ch / 8);
        localparam logic [7:0] DUTY_ADDR = 8'(32'h20 + ch);
        localparam int         BIT       = ch % 8;

        assign en_we[ch]   = wr.wr_valid && (wr.wr_addr == (8'h00 + BYTE_OFS));
        assign pe_we[ch]   = wr.wr_valid && (wr.wr_addr == (8'h10 + BYTE_OFS));
        assign pol_we[ch]  = wr.wr_valid && (wr.wr_addr == (8'h30 + BYTE_OFS));
        assign duty_we[ch] = wr.wr_valid && (wr.wr_addr == DUTY_ADDR) && !pol_addr_hit;
        assign wr_bit[ch]  = wr.wr_data[BIT];

        // A channel with pwm_en clear idles high (before out_en gating).
        assign raw_p0[ch]     = pwm_en[ch] ? (pwm_level(cnt_p0, duty_act[ch]) ^ polarity[ch])
                                           : 1'b1;
        assign out_nxt_p0[ch] = out_en[ch] & raw_p0[ch];
    end

    // ---- stage p0: prescaler and shared PWM counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_p0     <= '0;
            cnt_p0       <= '0;
            period_start <= 1'b0;
        end else begin
            presc_p0 <= tick_p0 ? '0 : presc_p0 + 1'b1;
            if (tick_p0) begin
                cnt_p0 <= (cnt_p0 == CNT_LAST) ? 8'd0 : cnt_p0 + 8'd1;
            end
            period_start <= wrap_p0;
        end
    end

    // ---- stage p0: control registers (take effect the cycle after the write) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_en   <= '0;
            pwm_en   <= '0;
            polarity <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (en_we[i]) begin
                    out_en[i] <= wr_bit[i];
                end
                if (pe_we[i]) begin
                    pwm_en[i] <= wr_bit[i];
                end
                if (pol_we[i]) begin
                    polarity[i] <= wr_bit[i];
                end
            end
        end
    end

`ifdef PWM_BANK_SHADOW_EN
    logic [7:0] duty_shd [N_CH];

    // ---- stage p0: shadowed duty, copied to active duty on the wrap ----
    // The copy reads the shadow's pre-edge value, so a write landing on the
    // wrap cycle is held over to the following wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                duty_shd[i] <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (duty_we[i]) begin
                    duty_shd[i] <= wr.wr_data;
                end
                if (wrap_p0) begin
                    duty_act[i] <= duty_shd[i];
                end
            end
        end
    end
`else
    // ---- stage p0: duty written straight to the active register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                duty_act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (duty_we[i]) begin
                    duty_act[i] <= wr.wr_data;
                end
            end
        end
    end
`endif

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= out_nxt_p0;
        end
    end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank -- self-checking bench for pwm_bank (N_CH=16, PRESCALE=4).
// A time-based reference model (counter derived from cycles since reset)
// is checked on every clock; table vectors and hand sequences add targeted
// expectations for static outputs, duty timing, polarity, and reset.
module tb_pwm_bank;

    localparam int N_CH     = 16;
    localparam int PRESCALE = 4;
    localparam int PERIOD   = 255 * PRESCALE;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] out;
    logic            period_start;

    pwm_bank_if ifc ();

    pwm_bank #(.N_CH(N_CH), .PRESCALE(PRESCALE)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (ifc.slave),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [15:0]   m_en, m_pe, m_pol;
    bit [7:0]    m_act [16];
    bit [7:0]    m_shd [16];
    int          m_t;
    logic [15:0] m_out;
    logic        m_ps;

    typedef struct {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_out;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] model_out(input int cnt);
        logic [15:0] o;
        bit          p;
        for (int i = 0; i < 16; i++) begin
            if (m_act[i] == 8'hFF) p = 1'b1;
            else                   p = (cnt < int'(m_act[i]));
            o[i] = m_en[i] & (m_pe[i] ? (p ^ m_pol[i]) : 1'b1);
        end
        return o;
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [7:0] d);
        int k;
        k = int'(a);
        if (k < 2) begin
            m_en[k*8 +: 8] = d;
        end else if (k >= 16 && k < 18) begin
            m_pe[(k-16)*8 +: 8] = d;
        end else if (k >= 32 && k < 48) begin
`ifdef PWM_BANK_SHADOW_EN
            m_shd[k-32] = d;
`else
            m_act[k-32] = d;
`endif
        end else if (k >= 48 && k < 50) begin
            m_pol[(k-48)*8 +: 8] = d;
        end
    endtask

    // One clock: advance the model with the inputs seen at this edge,
    // then compare the DUT 1 time unit later.
    task automatic step();
        int cnt;
        @(posedge clk);
        if (rst) begin
            m_en = '0; m_pe = '0; m_pol = '0;
            for (int i = 0; i < 16; i++) begin
                m_act[i] = '0;
                m_shd[i] = '0;
            end
            m_t   = 0;
            m_out = '0;
            m_ps  = 1'b0;
        end else begin
            cnt   = (m_t / PRESCALE) % 255;
            m_out = model_out(cnt);
            m_ps  = ((m_t + 1) % PERIOD) == 0;
`ifdef PWM_BANK_SHADOW_EN
            if (m_ps) begin
                for (int i = 0; i < 16; i++) m_act[i] = m_shd[i];
            end
`endif
            if (ifc.wr_valid) model_write(ifc.wr_addr, ifc.wr_data);
            m_t++;
        end
        #1;
        chk("model_out", out, m_out);
        chk("model_period_start", period_start, m_ps);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ifc.wr_valid = 1'b1;
        ifc.wr_addr  = a;
        ifc.wr_data  = d;
        step();
        ifc.wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Wait (bounded) for a period_start pulse; timeout counts as a failure.
    task automatic wait_ps();
        int n;
        n = 0;
        while (n < PERIOD + 50) begin
            step();
            n++;
            if (period_start === 1'b1) return;
        end
        chk("wait_period_start_timeout", 64'd0, 64'd1);
    endtask

    task automatic count_high(input int idx, input int ncyc, output int hi);
        hi = 0;
        repeat (ncyc) begin
            step();
            if (out[idx] === 1'b1) hi++;
        end
    endtask

    vec_t tbl [10];

    initial begin
        int hi;
        int n;
        int r;
        logic [7:0] a, d;

        tbl[0] = '{8'h00, 8'h01, 16'h0001};
        tbl[1] = '{8'h01, 8'hA5, 16'hA501};
        tbl[2] = '{8'h18, 8'hFF, 16'hA501};
        tbl[3] = '{8'h40, 8'hFF, 16'hA501};
        tbl[4] = '{8'h2F, 8'h20, 16'hA501};
        tbl[5] = '{8'h02, 8'hFF, 16'hA501};
        tbl[6] = '{8'h30, 8'hFF, 16'hA501};
        tbl[7] = '{8'h00, 8'hFF, 16'hA5FF};
        tbl[8] = '{8'h01, 8'h00, 16'h00FF};
        tbl[9] = '{8'h00, 8'h01, 16'h0001};

        rst          = 1'b1;
        ifc.wr_valid = 1'b0;
        ifc.wr_addr  = '0;
        ifc.wr_data  = '0;

        // Reset state
        do_reset();
        chk("reset_out", out, 16'h0000);
        chk("reset_period_start", period_start, 1'b0);

        // Static out_en vectors with pwm_en clear: out mirrors out_en one
        // clock after the register update; unmapped writes change nothing.
        for (int i = 0; i < 10; i++) begin
            wr(tbl[i].addr, tbl[i].data);
            step();
            chk($sformatf("tbl%0d_out", i), out, tbl[i].exp_out);
        end

        // period_start spacing
        wait_ps();
        n = 0;
        do begin
            step();
            n++;
        end while (period_start !== 1'b1 && n < PERIOD + 50);
        chk("period_start_interval", n, PERIOD);

        // Duty 0x80 on ch0: 512 high / 508 low per period
        do_reset();
        wr(8'h00, 8'h01);
        wr(8'h10, 8'h01);
        wr(8'h20, 8'h80);
        wait_ps();
        wait_ps();
        count_high(0, PERIOD, hi);
        chk("duty80_high", hi, 512);
        chk("duty80_low", PERIOD - hi, 508);

        // Inverted polarity, duty 0x40: 256 low / 764 high
        wr(8'h30, 8'h01);
        wr(8'h20, 8'h40);
        wait_ps();
        wait_ps();
        count_high(0, PERIOD, hi);
        chk("pol_low", PERIOD - hi, 256);
        chk("pol_high", hi, 764);

        // Duty extremes on ch3 over two full periods
        do_reset();
        wr(8'h00, 8'h08);
        wr(8'h10, 8'h08);
        wr(8'h23, 8'h00);
        wait_ps();
        wait_ps();
        count_high(3, 2 * PERIOD, hi);
        chk("duty00_ch3_high", hi, 0);
        wr(8'h23, 8'hFF);
        wait_ps();
        wait_ps();
        count_high(3, 2 * PERIOD, hi);
        chk("dutyFF_ch3_high", hi, 2 * PERIOD);

        // Reset mid-period with all channels active
        wr(8'h00, 8'hFF);
        wr(8'h01, 8'hFF);
        wr(8'h10, 8'hFF);
        wr(8'h11, 8'hFF);
        for (int i = 0; i < 16; i++) wr(8'(32'h20 + i), 8'h80);
        wait_ps();
        wait_ps();
        repeat (300) step();
        chk("pre_reset_out_active", out, 16'hFFFF);
        rst = 1'b1;
        step();
        chk("midreset_out", out, 16'h0000);
        chk("midreset_period_start", period_start, 1'b0);
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (period_start !== 1'b1 && n < PERIOD + 50);
        chk("first_ps_after_reset", n, PERIOD);

        // Randomized writes (occasional resets) against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else if (r < 120) begin
                case ($urandom_range(0, 7))
                    0: a = 8'h00;
                    1: a = 8'h01;
                    2: a = 8'h10;
                    3: a = 8'h11;
                    4: a = 8'h30;
                    5: a = 8'h31;
                    6: a = 8'(32'h20 + $urandom_range(0, 15));
                    default: a = 8'($urandom_range(0, 255));
                endcase
                case ($urandom_range(0, 3))
                    0: d = 8'h00;
                    1: d = 8'hFF;
                    default: d = 8'($urandom_range(0, 255));
                endcase
                wr(a, d);
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
